// File: rtl/dll_mq_pkg.sv
// rtl/dll_mq_pkg.sv - shared types and constants for the multi-queue linked-list engine
package dll_mq_pkg;

    localparam int NULL_PTR     = 0;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_PTR_W    = 8;
    localparam int DEF_WORD_W   = 32;

    typedef enum logic [2:0] {
        OP_POP_FRONT  = 3'b000,
        OP_POP_BACK   = 3'b001,
        OP_PUSH_FRONT = 3'b010,
        OP_PUSH_BACK  = 3'b011,
        OP_REMOVE     = 3'b100
    } op_t;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_t;

    typedef struct packed {
        logic [DEF_PTR_W-1:0] next;
        logic [DEF_PTR_W-1:0] prev;
    } ptr_pair_t;

    typedef struct packed {
        logic [DEF_PTR_W-1:0] head;
        logic [DEF_PTR_W-1:0] tail;
    } queue_t;

    typedef struct packed {
        logic                valid;
        logic [DEF_ID_W-1:0] id;
    } node_owner_t;

    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic [DEF_PTR_W-1:0]  ptr;
        logic [DEF_WORD_W-1:0] dat;
    } rsp_t;

endpackage

// File: rtl/dll_mq_if.sv
// rtl/dll_mq_if.sv - command/response/status bundle between client scheduler and dll_mq
interface dll_mq_if #(
    parameter int ID_N   = 4,
    parameter int PTR_N  = 256,
    parameter int WORD_W = 32
);
    localparam int ID_W  = (ID_N > 1) ? $clog2(ID_N) : 1;
    localparam int PTR_W = $clog2(PTR_N);

    logic                    cmd_vld;
    logic [2:0]              cmd_op;
    logic [ID_W-1:0]         cmd_id;
    logic [PTR_W-1:0]        cmd_ptr;
    logic [WORD_W-1:0]       cmd_dat;
    logic                    cmd_rdy;
    logic                    rsp_vld;
    logic                    rsp_err;
    logic [PTR_W-1:0]        rsp_ptr;
    logic [WORD_W-1:0]       rsp_dat;
    logic [ID_N-1:0]         empty;
    logic                    full;
    logic [ID_N*PTR_W-1:0]   cnt;

    modport master (
        output cmd_vld, cmd_op, cmd_id, cmd_ptr, cmd_dat,
        input  cmd_rdy, rsp_vld, rsp_err, rsp_ptr, rsp_dat, empty, full, cnt
    );

    modport slave (
        input  cmd_vld, cmd_op, cmd_id, cmd_ptr, cmd_dat,
        output cmd_rdy, rsp_vld, rsp_err, rsp_ptr, rsp_dat, empty, full, cnt
    );

endinterface

// File: rtl/dll_mq_freelist.sv
// rtl/dll_mq_freelist.sv - free-node stack with power-up link walk and full flag
module dll_mq_freelist
    import dll_mq_pkg::*;
#(
    parameter int PTR_N = 256,
    parameter int PTR_W = $clog2(PTR_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             free_en,
    input  logic [PTR_W-1:0] free_ptr,
    output logic             ready,
    output logic [PTR_W-1:0] head,
    output logic             full
);
    localparam logic [PTR_W-1:0] NIL  = PTR_W'(NULL_PTR);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(PTR_N - 1);

    fl_state_t        state_q, state_d;
    logic [PTR_W-1:0] init_q;
    logic [PTR_W-1:0] head_q;
    logic             full_q;
    logic             init_last;
    logic [PTR_W-1:0] free_nx [PTR_N];

    always_comb begin
        state_d   = state_q;
        init_last = 1'b0;
        case (state_q)
            FL_INIT: begin
                init_last = (init_q == LAST);
                if (init_last) state_d = FL_RUN;
            end
            default: state_d = FL_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FL_INIT;
            init_q  <= PTR_W'(1);
            head_q  <= NIL;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FL_INIT) begin
                init_q <= init_q + 1'b1;
                if (init_last) head_q <= PTR_W'(1);
            end else if (alloc) begin
                head_q <= free_nx[head_q];
                full_q <= (free_nx[head_q] == NIL);
            end else if (free_en) begin
                head_q <= free_ptr;
                full_q <= 1'b0;
            end
        end
    end

    // Links are rebuilt by the INIT walk after every reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == FL_INIT) begin
            free_nx[init_q] <= init_last ? NIL : init_q + 1'b1;
        end else if (free_en) begin
            free_nx[free_ptr] <= head_q;
        end
    end

    assign ready = (state_q == FL_RUN);
    assign head  = head_q;
    assign full  = full_q;

endmodule

// File: rtl/dll_mq.sv
// rtl/dll_mq.sv - multi-queue doubly-linked-list engine; DLL_MQ_OCCUPANCY_EN adds per-queue counters
module dll_mq
    import dll_mq_pkg::*;
#(
    parameter int ID_N   = 4,
    parameter int PTR_N  = 256,
    parameter int WORD_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    dll_mq_if.slave bus
);
    localparam int ID_W   = (ID_N > 1) ? $clog2(ID_N) : 1;
    localparam int PTR_W  = $clog2(PTR_N);
    localparam int ID_W1  = ID_W + 1;
    localparam int PTR_W1 = PTR_W + 1;
    localparam logic [PTR_W-1:0] NIL     = PTR_W'(NULL_PTR);
    localparam logic [ID_W:0]    ID_LIM  = ID_W1'(ID_N);
    localparam logic [PTR_W:0]   PTR_LIM = PTR_W1'(PTR_N);

    logic [PTR_W-1:0]  nxt_q    [PTR_N];
    logic [PTR_W-1:0]  prv_q    [PTR_N];
    logic [WORD_W-1:0] dat_q    [PTR_N];
    logic [ID_W-1:0]   own_id_q [PTR_N];
    logic [PTR_N-1:0]  own_vld_q;
    logic [PTR_W-1:0]  head_q   [ID_N];
    logic [PTR_W-1:0]  tail_q   [ID_N];

    logic              rsp_vld_q, rsp_err_q;
    logic [PTR_W-1:0]  rsp_ptr_q;
    logic [WORD_W-1:0] rsp_dat_q;

    logic              fl_ready, fl_full;
    logic [PTR_W-1:0]  fl_head;

    logic              acc, id_ok, op_legal, is_push, is_pop, is_rm, push_front;
    logic              p_in_range, rm_ok, q_empty, err, do_push, do_unlink;
    logic [ID_W-1:0]   id;
    logic [PTR_W-1:0]  q_head, q_tail, p_idx, rm_ptr, rm_prev, rm_next;

    always_comb begin
        acc        = bus.cmd_vld & fl_ready;
        id_ok      = {1'b0, bus.cmd_id} < ID_LIM;
        id         = id_ok ? bus.cmd_id : '0;
        op_legal   = bus.cmd_op <= 3'd4;
        is_pop     = (bus.cmd_op == OP_POP_FRONT)  || (bus.cmd_op == OP_POP_BACK);
        is_push    = (bus.cmd_op == OP_PUSH_FRONT) || (bus.cmd_op == OP_PUSH_BACK);
        is_rm      = (bus.cmd_op == OP_REMOVE);
        push_front = (bus.cmd_op == OP_PUSH_FRONT);
        q_head     = head_q[id];
        q_tail     = tail_q[id];
        q_empty    = (q_head == NIL);
        p_in_range = {1'b0, bus.cmd_ptr} < PTR_LIM;
        p_idx      = p_in_range ? bus.cmd_ptr : NIL;
        rm_ok      = p_in_range && (bus.cmd_ptr != NIL) && own_vld_q[p_idx] &&
                     (own_id_q[p_idx] == bus.cmd_id);
        err        = !id_ok || !op_legal || (is_push && fl_full) ||
                     (is_pop && q_empty) || (is_rm && !rm_ok);
        do_push    = acc && !err && is_push;
        do_unlink  = acc && !err && (is_pop || is_rm);
        // Pops are unlinks of the end node, so one unlink path serves pop and REMOVE.
        if (bus.cmd_op == OP_POP_FRONT)     rm_ptr = q_head;
        else if (bus.cmd_op == OP_POP_BACK) rm_ptr = q_tail;
        else                                rm_ptr = p_idx;
        rm_prev    = prv_q[rm_ptr];
        rm_next    = nxt_q[rm_ptr];
    end

    dll_mq_freelist #(
        .PTR_N (PTR_N),
        .PTR_W (PTR_W)
    ) u_freelist (
        .clk      (clk),
        .rst      (rst),
        .alloc    (do_push),
        .free_en  (do_unlink),
        .free_ptr (rm_ptr),
        .ready    (fl_ready),
        .head     (fl_head),
        .full     (fl_full)
    );

    always_ff @(posedge clk) begin
        if (do_push) begin
            dat_q[fl_head]    <= bus.cmd_dat;
            own_id_q[fl_head] <= bus.cmd_id;
            if (q_empty) begin
                nxt_q[fl_head] <= NIL;
                prv_q[fl_head] <= NIL;
            end else if (push_front) begin
                nxt_q[fl_head] <= q_head;
                prv_q[fl_head] <= NIL;
                prv_q[q_head]  <= fl_head;
            end else begin
                prv_q[fl_head] <= q_tail;
                nxt_q[fl_head] <= NIL;
                nxt_q[q_tail]  <= fl_head;
            end
        end else if (do_unlink) begin
            if (rm_prev != NIL) nxt_q[rm_prev] <= rm_next;
            if (rm_next != NIL) prv_q[rm_next] <= rm_prev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ID_N; i++) begin
                head_q[i] <= NIL;
                tail_q[i] <= NIL;
            end
            own_vld_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_ptr_q <= NIL;
            rsp_dat_q <= '0;
        end else begin
            rsp_vld_q <= acc;
            rsp_err_q <= acc && err;
            rsp_ptr_q <= do_push ? fl_head : (do_unlink ? rm_ptr : NIL);
            rsp_dat_q <= do_push ? bus.cmd_dat : (do_unlink ? dat_q[rm_ptr] : '0);
            if (do_push) begin
                own_vld_q[fl_head] <= 1'b1;
                if (q_empty) begin
                    head_q[id] <= fl_head;
                    tail_q[id] <= fl_head;
                end else if (push_front) begin
                    head_q[id] <= fl_head;
                end else begin
                    tail_q[id] <= fl_head;
                end
            end else if (do_unlink) begin
                own_vld_q[rm_ptr] <= 1'b0;
                if (rm_prev == NIL) head_q[id] <= rm_next;
                if (rm_next == NIL) tail_q[id] <= rm_prev;
            end
        end
    end

    for (genvar g = 0; g < ID_N; g++) begin : g_empty
        assign bus.empty[g] = (head_q[g] == NIL);
    end

`ifdef DLL_MQ_OCCUPANCY_EN
    logic [PTR_W-1:0] cnt_q [ID_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ID_N; i++) cnt_q[i] <= '0;
        end else if (do_push) begin
            cnt_q[id] <= cnt_q[id] + 1'b1;
        end else if (do_unlink) begin
            cnt_q[id] <= cnt_q[id] - 1'b1;
        end
    end

    for (genvar g = 0; g < ID_N; g++) begin : g_cnt
        assign bus.cnt[g*PTR_W +: PTR_W] = cnt_q[g];
    end
`else
    assign bus.cnt = '0;
`endif

    assign bus.cmd_rdy = fl_ready;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_err = rsp_err_q;
    assign bus.rsp_ptr = rsp_ptr_q;
    assign bus.rsp_dat = rsp_dat_q;
    assign bus.full    = fl_full;

endmodule
